// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-side inputs and parallel-side results of the UART receiver.
// master = tick generator / line driver side, slave = the receiver itself.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done;
  logic            frame_err;
  logic            parity_err;

  modport master (
    output s_tick, rx,
    input  dout, rx_done, frame_err, parity_err
  );

  modport slave (
    input  s_tick, rx,
    output dout, rx_done, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with start-glitch rejection and framing check.
// Define UART_RX_PARITY_EN to expect one parity bit (sense set by PAR_ODD) after the data.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PAR_ODD = 0
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = ($clog2(DBIT) > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] TICK_MID  = SW'(7);
  localparam logic [SW-1:0] TICK_END  = SW'(15);
  localparam logic [SW-1:0] TICK_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [1:0]      sync_q;
  logic [DBIT-1:0] dout_q;
  logic            done_q, done_d;
  logic            ferr_q;
  logic            rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      sync_q  <= 2'b11;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      sync_q  <= {sync_q[0], bus.rx};
      done_q  <= done_d;
      if (done_d) begin
        dout_q <= b_q;
        ferr_q <= ~rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q <= par_d;
      if (done_d) perr_q <= perr_d;
    end
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0 & 1'(PAR_ODD);
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          s_d     = '0;
        end
      end
      S_START: begin
        // a start bit that is gone by its centre was a glitch
        if (bus.s_tick) begin
          if (s_q == TICK_MID) begin
            if (!rx_s) begin
              state_d = S_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      S_DATA: begin
        if (bus.s_tick) begin
          if (s_q == TICK_END) begin
            b_d = {rx_s, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bus.s_tick) begin
          if (s_q == TICK_END) begin
            par_d   = rx_s;
            s_d     = '0;
            state_d = S_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      S_STOP: begin
        if (bus.s_tick) begin
          if (s_q == TICK_STOP) begin
            state_d = S_IDLE;
            s_d     = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done_d = (state_q == S_STOP) && bus.s_tick && (s_q == TICK_STOP);
`ifdef UART_RX_PARITY_EN
    perr_d = ((^b_q) ^ par_q) != 1'(PAR_ODD);
`endif
  end

  assign bus.dout      = dout_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and randomized frame checks for uart_rx at 4 clk per tick.
// Expected results come from a frame-level model: data word, stop level and parity count.
module tb_uart_rx;
  localparam int DBIT     = 8;
  localparam int PAR_ODD  = 0;
  localparam int BIT_CLK  = 64;

  logic clk;
  logic rst;

  uart_rx_if #(.DBIT(DBIT)) bus ();

  uart_rx #(.DBIT(DBIT), .SB_TICK(16), .PAR_ODD(PAR_ODD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         glitch_before;
    int         gap_after;
    logic [7:0] exp_dout;
    bit         exp_ferr;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int wide_pulse = 0;
  logic [9:0] mon_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    bus.s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.s_tick = 1'b1;
      @(negedge clk);
      bus.s_tick = 1'b0;
    end
  end

  // every sampled rx_done cycle is logged, so a stretched pulse shows up as an extra entry
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rx_done) begin
        mon_q.push_back({bus.dout, bus.frame_err, bus.parity_err});
        if (prev) wide_pulse++;
      end
      prev = bus.rx_done;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic good_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < DBIT; i++) ones += int'(d[i]);
    return ((ones + PAR_ODD) % 2) != 0;
  endfunction

  function automatic logic model_perr(input logic [7:0] d, input logic par);
    int ones = 0;
    for (int i = 0; i < DBIT; i++) ones += int'(d[i]);
    ones += int'(par);
    return (ones % 2) != PAR_ODD;
  endfunction

  task automatic drive(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  // a low stop bit is released after 3/4 of a bit so the restart it causes is rejected as a glitch
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input logic par);
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < DBIT; i++) drive(d[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
    drive(par, BIT_CLK);
`else
    if (par === 1'bx) bus.rx = 1'b1;
`endif
    if (stop_ok) drive(1'b1, BIT_CLK);
    else begin
      drive(1'b0, 48);
      drive(1'b1, 16);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] ed, input bit ef, input bit ep);
    int waited = 0;
    logic [9:0] e;
    while (mon_q.size() == 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (mon_q.size() == 0) begin
      check({tag, " rx_done timeout"}, mon_q.size(), 1);
    end else begin
      e = mon_q.pop_front();
      check({tag, " dout"}, int'(e[9:2]), int'(ed));
      check({tag, " frame_err"}, int'(e[1]), int'(ef));
      check({tag, " parity_err"}, int'(e[0]), int'(ep));
      check({tag, " extra rx_done"}, mon_q.size(), 0);
      check({tag, " dout held"}, int'(bus.dout), int'(ed));
    end
  endtask

  initial begin
    vec_t tbl[5];
    logic [7:0] d;
    bit         sok;
    logic       par;
    int         gap;

    tbl[0] = '{8'h55, 1'b1, 1'b0, 0,  8'h55, 1'b0};
    tbl[1] = '{8'hA3, 1'b1, 1'b0, 20, 8'hA3, 1'b0};
    tbl[2] = '{8'h3C, 1'b1, 1'b1, 10, 8'h3C, 1'b0};
    tbl[3] = '{8'hF0, 1'b0, 1'b0, 80, 8'hF0, 1'b1};
    tbl[4] = '{8'h0F, 1'b1, 1'b0, 10, 8'h0F, 1'b0};

    rst = 1'b1;
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset dout", int'(bus.dout), 0);
    check("reset rx_done", int'(bus.rx_done), 0);
    check("reset frame_err", int'(bus.frame_err), 0);
    check("reset parity_err", int'(bus.parity_err), 0);
    repeat (1000) @(negedge clk);
    check("idle no rx_done", mon_q.size(), 0);

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].glitch_before) begin
        d = bus.dout;
        drive(1'b0, 12);
        drive(1'b1, 100);
        check("glitch no rx_done", mon_q.size(), 0);
        check("glitch dout held", int'(bus.dout), int'(d));
      end
      send_frame(tbl[i].data, tbl[i].stop_ok, good_parity(tbl[i].data));
      expect_frame($sformatf("vec%0d", i), tbl[i].exp_dout, tbl[i].exp_ferr, 1'b0);
      drive(1'b1, tbl[i].gap_after);
    end

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    expect_frame("parity good", 8'h07, 1'b0, model_perr(8'h07, 1'b1));
    drive(1'b1, 10);
    send_frame(8'h07, 1'b1, 1'b0);
    expect_frame("parity bad", 8'h07, 1'b0, model_perr(8'h07, 1'b0));
    drive(1'b1, 10);
`endif

    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive(1'b1, BIT_CLK);
    bus.rx = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (700) @(negedge clk);
    check("abort no rx_done", mon_q.size(), 0);
    check("abort dout cleared", int'(bus.dout), 0);
    send_frame(8'hC3, 1'b1, good_parity(8'hC3));
    expect_frame("after abort", 8'hC3, 1'b0, 1'b0);
    drive(1'b1, 10);

    for (int k = 0; k < 20; k++) begin
      d   = 8'($urandom_range(0, 255));
      sok = ($urandom_range(0, 3) != 0);
      par = 1'($urandom_range(0, 1));
`ifndef UART_RX_PARITY_EN
      par = good_parity(d);
`endif
      gap = sok ? int'($urandom_range(0, 40)) : 64 + int'($urandom_range(0, 40));
      send_frame(d, sok, par);
      expect_frame($sformatf("rand%0d", k), d, !sok, model_perr(d, par));
      drive(1'b1, gap);
    end

    check("rx_done single cycle", wide_pulse, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
